// File: rtl/adc_serial_responder_if.sv
// Serial ADC link: shared DIN/SCLK command bus plus one DOUT/SSTRB pair per converter.
interface adc_serial_responder_if;
    logic ad_sclk;
    logic ad_din;
    logic ad_dout0;
    logic ad_sstrb0;
    logic ad_dout1;
    logic ad_sstrb1;

    modport master (
        output ad_sclk,
        output ad_din,
        input  ad_dout0,
        input  ad_sstrb0,
        input  ad_dout1,
        input  ad_sstrb1
    );

    modport slave (
        input  ad_sclk,
        input  ad_din,
        output ad_dout0,
        output ad_sstrb0,
        output ad_dout1,
        output ad_sstrb1
    );
endinterface

// File: rtl/adc_serial_responder.sv
// Slave end of the dual serial-ADC link: oversampled command decode and MSB-first result shift-out.
// Define PATTERN_GEN_EN to replace samp0/samp1 with per-channel counting test patterns.
module adc_serial_responder #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned TIMEOUT     = 4096,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    adc_serial_responder_if.slave  ad,
    output logic                   conv_req,
    output logic [2:0]             conv_chan,
    output logic                   conv_bip,
    input  logic [DATA_W-1:0]      samp0,
    input  logic [DATA_W-1:0]      samp1,
    output logic                   powered_down,
    output logic                   frame_err
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        LATCH,
        WAIT_FALL,
        SHIFT
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] din_sync;
    logic                   sclk_prev;
    logic                   rise;
    logic                   fall;
    logic                   din_s;
    logic [4:0]             bitcnt;
    logic [5:0]             cmd_sr;
    logic [DATA_W-1:0]      sh0;
    logic [DATA_W-1:0]      sh1;
    logic [TW-1:0]          tcnt;
    logic                   dout0;
    logic                   dout1;
    logic                   sstrb0;
    logic                   sstrb1;
    logic                   timed_out;

`ifdef PATTERN_GEN_EN
    logic [DATA_W-4:0]      pat_cnt [8];
    logic [DATA_W-1:0]      pat_word;
    logic                   unused_samp;

    assign pat_word    = {conv_chan, pat_cnt[conv_chan]};
    assign unused_samp = ^{samp0, samp1};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync <= '0;
            din_sync  <= '0;
            sclk_prev <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], ad.ad_sclk};
            din_sync  <= {din_sync[SYNC_STAGES-2:0], ad.ad_din};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
        end
    end

    // DIN comes from the same stage as the SCLK sample that reveals the edge.
    assign rise      = sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
    assign fall      = ~sclk_sync[SYNC_STAGES-1] & sclk_prev;
    assign din_s     = din_sync[SYNC_STAGES-1];
    assign timed_out = (state != IDLE) && !(rise || fall) && (tcnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            bitcnt       <= '0;
            cmd_sr       <= '0;
            sh0          <= '0;
            sh1          <= '0;
            tcnt         <= '0;
            dout0        <= 1'b0;
            dout1        <= 1'b0;
            sstrb0       <= 1'b0;
            sstrb1       <= 1'b0;
            conv_req     <= 1'b0;
            conv_chan    <= '0;
            conv_bip     <= 1'b0;
            powered_down <= 1'b0;
            frame_err    <= 1'b0;
`ifdef PATTERN_GEN_EN
            for (int unsigned i = 0; i < 8; i++) begin
                pat_cnt[i] <= '0;
            end
`endif
        end else begin
            conv_req  <= 1'b0;
            frame_err <= 1'b0;

            if (state == IDLE || rise || fall) begin
                tcnt <= '0;
            end else begin
                tcnt <= tcnt + 1'b1;
            end

            if (timed_out) begin
                frame_err <= 1'b1;
                dout0     <= 1'b0;
                dout1     <= 1'b0;
                sstrb0    <= 1'b0;
                sstrb1    <= 1'b0;
                tcnt      <= '0;
                state     <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise && din_s) begin
                            cmd_sr <= '0;
                            bitcnt <= 5'd1;
                            state  <= CMD;
                        end
                    end
                    CMD: begin
                        if (rise) begin
                            cmd_sr <= {cmd_sr[4:0], din_s};
                            bitcnt <= bitcnt + 1'b1;
                            // cmd_sr holds SEL2..0, BIP, SGL, PD1; din_s is PD0.
                            if (bitcnt == 5'd7) begin
                                if ({cmd_sr[0], din_s} == 2'b00) begin
                                    powered_down <= 1'b1;
                                    state        <= IDLE;
                                end else begin
                                    powered_down <= 1'b0;
                                    conv_chan    <= cmd_sr[5:3];
                                    conv_bip     <= cmd_sr[2];
                                    conv_req     <= 1'b1;
                                    state        <= LATCH;
                                end
                            end
                        end
                    end
                    LATCH: begin
`ifdef PATTERN_GEN_EN
                        sh0                 <= pat_word;
                        sh1                 <= ~pat_word;
                        pat_cnt[conv_chan]  <= pat_cnt[conv_chan] + 1'b1;
`else
                        sh0                 <= samp0;
                        sh1                 <= samp1;
`endif
                        state               <= WAIT_FALL;
                    end
                    WAIT_FALL: begin
                        if (fall) begin
                            sstrb0 <= 1'b1;
                            sstrb1 <= 1'b1;
                            dout0  <= sh0[DATA_W-1];
                            dout1  <= sh1[DATA_W-1];
                            sh0    <= {sh0[DATA_W-2:0], 1'b0};
                            sh1    <= {sh1[DATA_W-2:0], 1'b0};
                            bitcnt <= 5'd1;
                            state  <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (fall) begin
                            sstrb0 <= 1'b0;
                            sstrb1 <= 1'b0;
                            if (bitcnt < 5'(DATA_W)) begin
                                dout0  <= sh0[DATA_W-1];
                                dout1  <= sh1[DATA_W-1];
                                sh0    <= {sh0[DATA_W-2:0], 1'b0};
                                sh1    <= {sh1[DATA_W-2:0], 1'b0};
                                bitcnt <= bitcnt + 1'b1;
                            end else begin
                                dout0  <= 1'b0;
                                dout1  <= 1'b0;
                                state  <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign ad.ad_dout0  = dout0;
    assign ad.ad_dout1  = dout1;
    assign ad.ad_sstrb0 = sstrb0;
    assign ad.ad_sstrb1 = sstrb1;

endmodule

// File: tb/tb_adc_serial_responder.sv
// Randomized self-checking bench for adc_serial_responder against a frame-level reference model.
module tb_adc_serial_responder;

    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 4096;
    localparam int SYNC    = 2;
    localparam int HALF    = 8;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              conv_req;
    logic [2:0]        conv_chan;
    logic              conv_bip;
    logic [DATA_W-1:0] samp0;
    logic [DATA_W-1:0] samp1;
    logic              powered_down;
    logic              frame_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int req_cnt = 0;
    int ferr_cnt = 0;
    int ferr_cyc = 0;
    int strb0_cyc = 0;
    int strb1_cyc = 0;
    int nz_cnt = 0;

    logic [12:0] pat_model [8];

    adc_serial_responder_if bus ();

    adc_serial_responder #(
        .DATA_W      (DATA_W),
        .TIMEOUT     (TIMEOUT),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ad           (bus.slave),
        .conv_req     (conv_req),
        .conv_chan    (conv_chan),
        .conv_bip     (conv_bip),
        .samp0        (samp0),
        .samp1        (samp1),
        .powered_down (powered_down),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (conv_req)       req_cnt++;
        if (frame_err)      begin ferr_cnt++; ferr_cyc = cyc; end
        if (bus.ad_sstrb0)  strb0_cyc++;
        if (bus.ad_sstrb1)  strb1_cyc++;
        if (reset_n && (conv_req || frame_err || powered_down || conv_bip || conv_chan != 3'd0 ||
                        bus.ad_dout0 || bus.ad_dout1 || bus.ad_sstrb0 || bus.ad_sstrb1))
            nz_cnt++;
    end

    task automatic clk_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sclk_bit(input logic b);
        bus.ad_din = b;
        clk_wait(HALF);
        bus.ad_sclk = 1'b1;
        clk_wait(HALF);
        bus.ad_sclk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] c);
        for (int i = 7; i >= 0; i--) sclk_bit(c[i]);
    endtask

    // Master side of the result phase: sample DOUT/SSTRB just before each of 16 rises.
    task automatic read_result(input logic din_level,
                               output logic [15:0] d0, output logic [15:0] d1,
                               output logic [15:0] st0, output logic [15:0] st1);
        d0 = '0; d1 = '0; st0 = '0; st1 = '0;
        for (int i = 0; i < DATA_W; i++) begin
            bus.ad_din = din_level;
            clk_wait(HALF);
            d0  = {d0[14:0], bus.ad_dout0};
            d1  = {d1[14:0], bus.ad_dout1};
            st0 = {st0[14:0], bus.ad_sstrb0};
            st1 = {st1[14:0], bus.ad_sstrb1};
            bus.ad_sclk = 1'b1;
            clk_wait(HALF);
            bus.ad_sclk = 1'b0;
        end
        clk_wait(HALF);
    endtask

    // Reference: what each converter should return for a command given the sample inputs.
    task automatic model_result(input logic [7:0] cmd, input logic [15:0] s0, input logic [15:0] s1,
                                output logic [15:0] e0, output logic [15:0] e1);
        int ch;
        ch = (cmd / 16) % 8;
`ifdef PATTERN_GEN_EN
        e0 = 16'(ch * 8192 + int'(pat_model[ch]));
        e1 = ~e0;
        pat_model[ch] = pat_model[ch] + 13'd1;
`else
        e0 = s0;
        e1 = s1;
        if (ch < 0) e0 = '0;
`endif
    endtask

    task automatic do_frame(input logic [7:0] cmd, input logic [15:0] s0, input logic [15:0] s1,
                            input logic din_level,
                            output logic [15:0] d0, output logic [15:0] d1,
                            output logic [15:0] st0, output logic [15:0] st1);
        samp0 = s0;
        samp1 = s1;
        send_byte(cmd);
        read_result(din_level, d0, d1, st0, st1);
        bus.ad_din = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) sclk_bit(1'b1);
        checks++;
        if ({conv_req, conv_chan, conv_bip, powered_down, frame_err,
             bus.ad_dout0, bus.ad_sstrb0, bus.ad_dout1, bus.ad_sstrb1} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 0", {conv_req, conv_chan, conv_bip, powered_down,
                     frame_err, bus.ad_dout0, bus.ad_sstrb0, bus.ad_dout1, bus.ad_sstrb1});
        end
        checks++;
        if (req_cnt !== 0) begin
            errors++;
            $display("FAIL reset_no_req: got %0d required 0", req_cnt);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) sclk_bit(1'b0);
        clk_wait(HALF);
        checks++;
        if (nz_cnt !== 0) begin
            errors++;
            $display("FAIL idle_quiet: nonzero-output cycles %0d required 0", nz_cnt);
        end
        checks++;
        if (req_cnt !== 0) begin
            errors++;
            $display("FAIL idle_no_req: got %0d required 0", req_cnt);
        end
    endtask

    task automatic check_conversion(input string tag, input logic [7:0] cmd,
                                    input logic [15:0] s0, input logic [15:0] s1, input logic din_level);
        logic [15:0] d0, d1, st0, st1, e0, e1;
        int r0, sc0, sc1;
        r0 = req_cnt; sc0 = strb0_cyc; sc1 = strb1_cyc;
        model_result(cmd, s0, s1, e0, e1);
        do_frame(cmd, s0, s1, din_level, d0, d1, st0, st1);
        checks++;
        if (req_cnt - r0 !== 1) begin
            errors++; $display("FAIL %s conv_req count: got %0d required 1", tag, req_cnt - r0);
        end
        checks++;
        if (conv_chan !== 3'((cmd / 16) % 8) || conv_bip !== cmd[3]) begin
            errors++;
            $display("FAIL %s fields: chan %0d bip %0d required chan %0d bip %0d",
                     tag, conv_chan, conv_bip, (cmd / 16) % 8, cmd[3]);
        end
        checks++;
        if (powered_down !== 1'b0) begin
            errors++; $display("FAIL %s powered_down: got %b required 0", tag, powered_down);
        end
        checks++;
        if (d0 !== e0 || d1 !== e1) begin
            errors++; $display("FAIL %s data: got %h/%h required %h/%h", tag, d0, d1, e0, e1);
        end
        checks++;
        if (st0 !== 16'h8000 || st1 !== 16'h8000) begin
            errors++; $display("FAIL %s sstrb pattern: got %h/%h required 8000/8000", tag, st0, st1);
        end
        checks++;
        if (strb0_cyc - sc0 !== 2 * HALF || strb1_cyc - sc1 !== 2 * HALF) begin
            errors++;
            $display("FAIL %s sstrb width: got %0d/%0d clk required %0d", tag,
                     strb0_cyc - sc0, strb1_cyc - sc1, 2 * HALF);
        end
        checks++;
        if ({bus.ad_dout0, bus.ad_dout1, bus.ad_sstrb0, bus.ad_sstrb1} !== 4'b0) begin
            errors++;
            $display("FAIL %s end idle: got %b required 0000", tag,
                     {bus.ad_dout0, bus.ad_dout1, bus.ad_sstrb0, bus.ad_sstrb1});
        end
    endtask

    task automatic test_conversion;
        logic [7:0] cmd;
        check_conversion("conv_b5", 8'hB5, 16'hA5C3, 16'h1234, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cmd = {1'b1, 5'($urandom_range(0, 31)), 2'($urandom_range(1, 3))};
            check_conversion("conv_rand", cmd, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_power_down;
        int r0, sc0;
        logic [2:0] ch0;
        logic bip0;
        r0 = req_cnt; sc0 = strb0_cyc + strb1_cyc; ch0 = conv_chan; bip0 = conv_bip;
        send_byte(8'h8C);
        for (int i = 0; i < 18; i++) sclk_bit(1'b0);
        clk_wait(HALF);
        checks++;
        if (powered_down !== 1'b1) begin
            errors++; $display("FAIL pd_set: got %b required 1", powered_down);
        end
        checks++;
        if (req_cnt - r0 !== 0 || strb0_cyc + strb1_cyc - sc0 !== 0) begin
            errors++;
            $display("FAIL pd_quiet: conv_req %0d sstrb cycles %0d required 0/0", req_cnt - r0,
                     strb0_cyc + strb1_cyc - sc0);
        end
        checks++;
        if (conv_chan !== ch0 || conv_bip !== bip0) begin
            errors++;
            $display("FAIL pd_fields: got chan %0d bip %b required chan %0d bip %b", conv_chan, conv_bip, ch0, bip0);
        end
        check_conversion("pd_wake_8f", 8'h8F, 16'($urandom), 16'($urandom), 1'b0);
    endtask

    task automatic test_timeout;
        int f0, r0, edge_cyc, dt;
        logic [2:0] ch0;
        logic bip0, pd0;
        f0 = ferr_cnt; r0 = req_cnt; ch0 = conv_chan; bip0 = conv_bip; pd0 = powered_down;
        sclk_bit(1'b1); sclk_bit(1'b0); sclk_bit(1'b1); sclk_bit(1'b1);
        edge_cyc = cyc;
        clk_wait(5000);
        dt = ferr_cyc - edge_cyc;
        checks++;
        if (ferr_cnt - f0 !== 1) begin
            errors++; $display("FAIL timeout_pulses: got %0d required 1", ferr_cnt - f0);
        end
        checks++;
        if (dt < TIMEOUT || dt > TIMEOUT + SYNC + 3) begin
            errors++;
            $display("FAIL timeout_delay: got %0d clk required %0d..%0d", dt, TIMEOUT, TIMEOUT + SYNC + 3);
        end
        checks++;
        if (conv_chan !== ch0 || conv_bip !== bip0 || powered_down !== pd0 || req_cnt !== r0) begin
            errors++;
            $display("FAIL timeout_keep: chan %0d bip %b pd %b req %0d required %0d %b %b %0d",
                     conv_chan, conv_bip, powered_down, req_cnt, ch0, bip0, pd0, r0);
        end
        checks++;
        if ({bus.ad_dout0, bus.ad_dout1, bus.ad_sstrb0, bus.ad_sstrb1} !== 4'b0) begin
            errors++; $display("FAIL timeout_outputs: got nonzero required 0000");
        end
        check_conversion("timeout_recover_8f", 8'h8F, 16'($urandom), 16'($urandom), 1'b0);
    endtask

    task automatic test_leading_zeros;
        int r0;
        for (int i = 0; i < 3; i++) sclk_bit(1'b0);
        check_conversion("lead_9d", 8'h9D, 16'($urandom), 16'($urandom), 1'b1);
        r0 = req_cnt;
        for (int i = 0; i < 4; i++) sclk_bit(1'b0);
        clk_wait(HALF);
        checks++;
        if (conv_chan !== 3'd1 || conv_bip !== 1'b1 || req_cnt !== r0) begin
            errors++;
            $display("FAIL lead_no_second_cmd: chan %0d bip %b extra req %0d required 1 1 0",
                     conv_chan, conv_bip, req_cnt - r0);
        end
    endtask

`ifdef PATTERN_GEN_EN
    task automatic test_pattern;
        for (int i = 0; i < 3; i++) check_conversion("pattern_b5", 8'hB5, 16'($urandom), 16'($urandom), 1'b0);
    endtask
`endif

    initial begin
        for (int i = 0; i < 8; i++) pat_model[i] = '0;
        bus.ad_sclk = 1'b0;
        bus.ad_din  = 1'b0;
        samp0 = '0;
        samp1 = '0;
        clk_wait(4);
        test_reset;
        test_conversion;
        test_power_down;
        test_timeout;
        test_leading_zeros;
`ifdef PATTERN_GEN_EN
        test_pattern;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_serial_responder.md
Name: adc_serial_responder

Overview:
- Synthesizable responder for the dual serial-ADC link: the slave end of the shared DIN/SCLK command bus, with one DOUT/SSTRB pair per converter.
- Oversamples the master's SCLK and DIN in the system clock domain.
- Decodes the 8-bit control byte and strobes a conversion request to a sample source.
- Shifts two DATA_W-bit results back MSB-first with an SSTRB marker.
- Used for board loopback (replaces the physical converters) and as the bench partner for the ADC master.

Parameters:
- DATA_W, 16: result width in bits, 8..16.
- TIMEOUT, 4096: clk cycles without an SCLK edge before an in-progress frame is aborted.
- SYNC_STAGES, 2: synchronizer depth on ad_sclk and ad_din, 2..3.

Ports:
- clk  in  1: system clock; must be >= 8x SCLK frequency.
- reset_n  in  1: asynchronous active-low reset.
- ad_sclk  in  1: serial clock from the master.
- ad_din  in  1: command data from the master; sampled on SCLK rising edges.
- ad_dout0  out  1: serial result, converter 0; changes on SCLK falling edges.
- ad_sstrb0  out  1: result-start strobe, converter 0.
- ad_dout1  out  1: serial result, converter 1.
- ad_sstrb1  out  1: result-start strobe, converter 1.
- conv_req  out  1: one-clk pulse requesting a conversion.
- conv_chan  out  3: channel field of the last accepted command.
- conv_bip  out  1: bipolar flag of the last accepted command (1 = bipolar).
- samp0  in  DATA_W: converter-0 result; sampled 1 clk after conv_req.
- samp1  in  DATA_W: converter-1 result; sampled 1 clk after conv_req.
- powered_down  out  1: set by a power-down command.
- frame_err  out  1: one-clk pulse when a frame is aborted by timeout.

Behaviour:
- Reset (async assert, sync deassert):
  - All outputs are 0.
  - Synchronizers clear; FSM goes to IDLE.
- Edge detection:
  - rise/fall are derived from the last two synchronized SCLK samples.
  - DIN is taken from the same synchronizer stage as the SCLK sample that shows the edge.
- Pin-to-pin latency: SCLK pin falling edge to DOUT/SSTRB update is SYNC_STAGES+1 clk.
- Control byte, MSB first: START(1), SEL2..0, BIP, SGL, PD1, PD0.
- FSM states:
  - IDLE: on rise with din=1 -> CMD, bitcnt=1. On rise with din=0, stay (leading zeros ignored).
  - CMD: each rise shifts din in and increments bitcnt. At bitcnt=8:
    - PD1:PD0=00: set powered_down=1, update no other field, -> IDLE.
    - Otherwise: clear powered_down, latch conv_chan/conv_bip, pulse conv_req, -> LATCH.
  - LATCH: next clk captures samp0/samp1 into the shift registers -> WAIT_FALL.
  - WAIT_FALL: on the next fall:
    - Drive both sstrb=1 and dout=result MSB.
    - bitcnt=1 -> SHIFT.
  - SHIFT: on each fall:
    - Drive both sstrb=0 at the first fall after strobing.
    - If bitcnt<DATA_W: shift next bit out on both douts and increment bitcnt.
    - At bitcnt=DATA_W (the fall after the LSB was presented): douts=0, -> IDLE.
- Timing with respect to the master:
  - SSTRB is high for exactly one SCLK period.
  - The master samples the MSB on the rise following SSTRB.
- DIN is ignored in LATCH, WAIT_FALL and SHIFT. A new START is accepted only from IDLE.
- Timeout:
  - In any state other than IDLE, a counter of clk cycles since the last SCLK edge runs.
  - On reaching TIMEOUT: pulse frame_err, douts=0, sstrbs=0, -> IDLE.
  - conv_chan, conv_bip and powered_down keep their values.
- A rise and a fall can never occur in the same clk; edges closer than 2 clk apart are out of spec and not checked.
- A powered_down=1 state does not block commands; the next non-PD byte clears it.

Optional Feature:
- PATTERN_GEN_EN defined:
  - samp0/samp1 are ignored.
  - A per-channel 8-entry array of (DATA_W-3)-bit counters is kept.
  - Captured value = {conv_chan, counter[conv_chan]} for converter 0, and its bitwise inverse for converter 1.
  - The selected counter increments (wrapping) at each capture; all counters clear at reset.
- Undefined: results come from samp0/samp1 as above; no counter logic is synthesized.

Test Plan:
- Reset:
  - Stimulus: reset_n low with SCLK toggling.
  - Required: all outputs 0, no conv_req.
  - After release with DIN=0 for 20 SCLKs: FSM remains IDLE, no outputs change.
- Conversion:
  - Stimulus: command 0xB5 (chan 3, BIP=0, PD=01), samp0=0xA5C3, samp1=0x1234.
  - Required: one conv_req, conv_chan=3, conv_bip=0.
  - Required: SSTRB pulse one SCLK wide on both converters; DOUT0 reads 0xA5C3 and DOUT1 reads 0x1234 on the 16 following rises; DOUTs return to 0.
- Power-down:
  - Stimulus: command 0x8C (PD=00).
  - Required: powered_down=1, no conv_req, no SSTRB.
  - Then command 0x8F: powered_down=0, conversion proceeds.
- Timeout:
  - Stimulus: stop SCLK after 4 command bits for 5000 clk.
  - Required: single frame_err pulse at TIMEOUT, FSM IDLE.
  - Next valid 0x8F frame completes normally.
- Leading zeros and ignored DIN:
  - Stimulus: 3 zero bits, then 0x9D; DIN held high throughout the result phase.
  - Required: conv_chan=1, conv_bip=1.
  - Required: no second command is decoded during SHIFT.
- PATTERN_GEN_EN build:
  - Stimulus: three 0xB5 frames.
  - Required: DOUT0 reads 0x6000, 0x6001, 0x6002; DOUT1 reads the inverses 0x9FFF, 0x9FFE, 0x9FFD.
